// File: rtl/fp8_arb_pkg.sv
// Shared types and constants for the FP8 add/sub arbiter: field positions, tag format, drain FSM states.
package fp8_arb_pkg;
  localparam int FP8_W   = 8;
  localparam int EXC_W   = 5;
  localparam int EXP_MSB = 6;
  localparam int EXP_LSB = 4;
  localparam int TAG_IDW = 3;

  localparam logic [FP8_W-1:0] FP8_QNAN = 8'h7F;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
    logic               bypass;
  } tag_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  // All-ones exponent marks NaN or Inf.
  function automatic logic is_special(input logic [FP8_W-1:0] x);
    return &x[EXP_MSB:EXP_LSB];
  endfunction
endpackage

// File: rtl/fp8_rr_picker.sv
// Combinational round-robin selector: first requester at or above ptr, wrapping modulo N.
// Zero latency; no state, the caller owns the pointer.
module fp8_rr_picker #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any && req[i] && (i == (int'(ptr) + k) % N)) begin
          any      = 1'b1;
          grant[i] = 1'b1;
          idx      = W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/fp8_addsub_arbiter.sv
// Round-robin sharing of one LAT-cycle FP8 add/sub datapath; accept-to-response LAT+2, 1 op/cycle, no rsp backpressure.
// FP8_ARB_EXC_BYPASS_EN: NaN/Inf operands are resolved locally and ride the tag pipeline instead of the datapath.
module fp8_addsub_arbiter
  import fp8_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int IDW  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [8*NREQ-1:0]     req_a,
  input  logic [8*NREQ-1:0]     req_b,
  input  logic [NREQ-1:0]       req_op,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy,
  output logic                  fpu_start,
  output logic [FP8_W-1:0]      fpu_a,
  output logic [FP8_W-1:0]      fpu_b,
  output logic                  fpu_op,
  input  logic [FP8_W-1:0]      fpu_result,
  input  logic [EXC_W-1:0]      fpu_exc,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [FP8_W-1:0]      rsp_result,
  output logic [EXC_W-1:0]      rsp_exc
);
  arb_state_t state, state_nxt;
  logic drained;
  logic [IDW-1:0] ptr, win;
  logic [NREQ-1:0] grant;
  logic any_req, arb_en, xfer, tags_empty;
  logic [FP8_W-1:0] a_sel, b_sel;
  logic op_sel;

  tag_t             tag_q   [LAT+1];
  logic [FP8_W-1:0] byp_res_q [LAT+1];
  logic [EXC_W-1:0] byp_exc_q [LAT+1];

  logic byp_now, a_sp, b_sp, a_nan, b_nan, a_inf, b_inf, b_eff;
  logic [FP8_W-1:0] byp_res_now;
  logic [EXC_W-1:0] byp_exc_now;

  fp8_rr_picker #(.N(NREQ), .W(IDW)) u_picker (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any_req)
  );

  // flush wins over a same-cycle grant; reset also forces ready low
  assign arb_en    = (state == RUN) && !flush && !rst;
  assign req_ready = arb_en ? grant : '0;
  assign xfer      = arb_en && any_req;

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel  = req_a[8*i +: 8];
        b_sel  = req_b[8*i +: 8];
        op_sel = req_op[i];
      end
    end
  end

  assign a_sp  = is_special(a_sel);
  assign b_sp  = is_special(b_sel);
  assign a_nan = a_sp & (|a_sel[EXP_LSB-1:0]);
  assign b_nan = b_sp & (|b_sel[EXP_LSB-1:0]);
  assign a_inf = a_sp & ~(|a_sel[EXP_LSB-1:0]);
  assign b_inf = b_sp & ~(|b_sel[EXP_LSB-1:0]);
  assign b_eff = b_sel[FP8_W-1] ^ op_sel;
  assign byp_exc_now = {a_nan | b_nan | a_inf | b_inf, a_nan, b_nan, a_inf, b_inf};

  always_comb begin
    byp_res_now = {b_eff, b_sel[FP8_W-2:0]};
    if (a_inf) byp_res_now = a_sel;
    if ((a_inf && b_inf && (a_sel[FP8_W-1] != b_eff)) || a_nan || b_nan) byp_res_now = FP8_QNAN;
  end

`ifdef FP8_ARB_EXC_BYPASS_EN
  assign byp_now = a_sp | b_sp;
`else
  assign byp_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      fpu_start <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_op    <= 1'b0;
    end else begin
      fpu_start <= xfer && !byp_now;
      if (xfer) begin
        ptr    <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
        fpu_a  <= a_sel;
        fpu_b  <= b_sel;
        fpu_op <= op_sel;
      end
    end
  end

  // Stage 0 coincides with fpu_start; stage LAT coincides with fpu_result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= LAT; k++) begin
        tag_q[k]     <= '0;
        byp_res_q[k] <= '0;
        byp_exc_q[k] <= '0;
      end
    end else begin
      tag_q[0].valid  <= xfer;
      tag_q[0].id     <= TAG_IDW'(win);
      tag_q[0].bypass <= xfer && byp_now;
      byp_res_q[0]    <= byp_res_now;
      byp_exc_q[0]    <= byp_exc_now;
      for (int k = 1; k <= LAT; k++) begin
        tag_q[k]     <= tag_q[k-1];
        byp_res_q[k] <= byp_res_q[k-1];
        byp_exc_q[k] <= byp_exc_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_exc    <= '0;
    end else begin
      rsp_valid <= tag_q[LAT].valid ? (NREQ'(1) << tag_q[LAT].id) : '0;
      if (tag_q[LAT].valid) begin
        rsp_result <= tag_q[LAT].bypass ? byp_res_q[LAT] : fpu_result;
        rsp_exc    <= tag_q[LAT].bypass ? byp_exc_q[LAT] : fpu_exc;
      end
    end
  end

  always_comb begin
    tags_empty = 1'b1;
    for (int k = 0; k <= LAT; k++) begin
      if (tag_q[k].valid) tags_empty = 1'b0;
    end
  end

  assign busy       = !tags_empty || (|rsp_valid);
  assign flush_done = (state == DONE);

  // drained keeps a held flush parked in DRAIN so flush_done fires only once
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN: begin
        if (drained) begin
          if (!flush) state_nxt = RUN;
        end else if (tags_empty && !xfer) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = flush ? DRAIN : RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      drained <= 1'b0;
    end else begin
      state   <= state_nxt;
      drained <= (state_nxt == DRAIN) && (drained || (state == DONE));
    end
  end
endmodule
